// File: rtl/vga_frame_ctrl_if.sv
// VGA frame controller bus: run request, external pixel colour in, timing and colour out.
// Latency: none; this is only a signal bundle.
// Backpressure: none; the VGA stream is free-running once started.
//
// Modports:
//   master : pixel source side. Drives enable/R/G/B and observes the timing outputs.
//   slave  : controller side. Samples enable/R/G/B and drives the timing and colour outputs.
interface vga_frame_ctrl_if;
  logic       enable;
  logic [3:0] R;
  logic [3:0] G;
  logic [3:0] B;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       horizontal_sync;
  logic       vertical_sync;
  logic       display_en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output enable, R, G, B,
    input  red, green, blue, horizontal_sync, vertical_sync, display_en,
    input  h_count, v_count, pix_tick, frame_start
  );

  modport slave (
    input  enable, R, G, B,
    output red, green, blue, horizontal_sync, vertical_sync, display_en,
    output h_count, v_count, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_frame_ctrl.sv
// 640x480@60 VGA frame controller: pixel tick from 50 MHz clk, h/v counters, sync/enable/colour decode.
// Latency: sync, display_en and colour lag h_count/v_count by 1 clk; first counter step 2 clk after start.
// Backpressure: none; start/stop requests on enable are honoured only at frame boundaries.
//
// Ports: clk (50 MHz, only clock), reset (synchronous, active-low), bus (vga_frame_ctrl_if.slave):
//   enable, R/G/B in; red/green/blue, horizontal_sync, vertical_sync, display_en,
//   h_count, v_count, pix_tick, frame_start out.
// Optional feature: define VGA_BORDER_EN to overlay a BORDER_W-thick BORDER_RGB frame on the picture.
module vga_frame_ctrl #(
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33,
  parameter int          BORDER_W   = 11,
  parameter logic [11:0] BORDER_RGB = 12'h00F
) (
  input  logic             clk,
  input  logic             reset,
  vga_frame_ctrl_if.slave  bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       start_nxt;
  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       wrap;
  logic       visible;
  logic       border;
  logic [11:0] pix_rgb;

  logic       hsync_q;
  logic       vsync_q;
  logic       de_q;
  logic [11:0] rgb_q;
  logic       fstart_q;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  // The counters only move on a tick, so this is the edge that returns them to (0,0).
  assign wrap   = tick && h_last && v_last;

  // Next state and the frame_start request. A stop in RUN never ends the frame early:
  // it only parks in DRAIN, which leaves for IDLE on the wrap or resumes on enable.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nxt = RUN;
          start_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!bus.enable) state_nxt = DRAIN;
        if (wrap)        start_nxt = 1'b1;
      end
      DRAIN: begin
        if (bus.enable) begin
          state_nxt = RUN;
          if (wrap) start_nxt = 1'b1;
        end else if (wrap) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tick  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        tick  <= 1'b0;
        h_cnt <= '0;
        v_cnt <= '0;
      end else begin
        tick <= ~tick;
        if (tick) begin
          if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
        end
      end
    end
  end

  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS) && (state != IDLE);

`ifdef VGA_BORDER_EN
  localparam logic [9:0] B_LO  = 10'(BORDER_W);
  localparam logic [9:0] B_HR  = 10'(H_VISIBLE - BORDER_W);
  localparam logic [9:0] B_VB  = 10'(V_VISIBLE - BORDER_W);

  assign border  = (h_cnt < B_LO) || (h_cnt >= B_HR) || (v_cnt < B_LO) || (v_cnt >= B_VB);
  assign pix_rgb = !visible ? 12'h000 : (border ? BORDER_RGB : {bus.R, bus.G, bus.B});
`else
  // Border overlay compiled out; the configuration is kept only as a named sink.
  logic unused_border_cfg;
  assign unused_border_cfg = ^{BORDER_W, BORDER_RGB};
  assign border  = 1'b0;
  assign pix_rgb = (visible && !border) ? {bus.R, bus.G, bus.B} : 12'h000;
`endif

  // Decode from the pre-edge counters, so these outputs trail h_count/v_count by one clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      rgb_q    <= '0;
      fstart_q <= 1'b0;
    end else begin
      hsync_q  <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync_q  <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      de_q     <= visible;
      rgb_q    <= pix_rgb;
      fstart_q <= start_nxt;
    end
  end

  assign bus.horizontal_sync = hsync_q;
  assign bus.vertical_sync   = vsync_q;
  assign bus.display_en      = de_q;
  assign bus.red             = rgb_q[11:8];
  assign bus.green           = rgb_q[7:4];
  assign bus.blue            = rgb_q[3:0];
  assign bus.h_count         = h_cnt;
  assign bus.v_count         = v_cnt;
  assign bus.pix_tick        = tick;
  assign bus.frame_start     = fstart_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Randomized scoreboard bench for vga_frame_ctrl with shrunken timing parameters.
// The reference model tracks clocks elapsed since the frame started and derives
// pixel position, tick phase and decoded outputs arithmetically.
module tb_vga_frame_ctrl;

  localparam int HV = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 12;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int BW = 3;
  localparam logic [11:0] BRGB = 12'h00F;

  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLKS = 2 * HT * VT;
  localparam int NCYC = 14000;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        tick;
    logic        fs;
  } obs_t;

  logic clk;
  logic reset;

  vga_frame_ctrl_if bus();

  vga_frame_ctrl #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .BORDER_W  (BW), .BORDER_RGB (BRGB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: running flag, stop pending, clocks since frame start.
  bit   active   = 1'b0;
  bit   draining = 1'b0;
  int   k        = 0;

  task automatic model_step(input logic rst_n, input logic en,
                            input logic [11:0] ext, output obs_t o);
    int hp;
    int vp;
    bit vis;
    bit brd;
    hp = (k / 2) % HT;
    vp = (k / 2) / HT;
    o = '0;
    if (!rst_n) begin
      active   = 1'b0;
      draining = 1'b0;
      k        = 0;
      o.hs     = 1'b1;
      o.vs     = 1'b1;
    end else begin
      o.hs = !(hp >= HV + HF && hp < HV + HF + HS);
      o.vs = !(vp >= VV + VF && vp < VV + VF + VS);
      vis  = active && hp < HV && vp < VV;
`ifdef VGA_BORDER_EN
      brd  = hp < BW || hp >= HV - BW || vp < BW || vp >= VV - BW;
`else
      brd  = 1'b0;
`endif
      o.de  = vis;
      o.rgb = !vis ? 12'h000 : (brd ? BRGB : ext);
      if (!active) begin
        if (en) begin
          active   = 1'b1;
          draining = 1'b0;
          k        = 0;
          o.fs     = 1'b1;
        end
      end else begin
        k = k + 1;
        if (k == FRAME_CLKS) begin
          k = 0;
          if (draining && !en) active = 1'b0;
          else                 o.fs   = 1'b1;
        end
        draining = !en;
      end
    end
    o.h    = 10'((k / 2) % HT);
    o.v    = 10'((k / 2) / HT);
    o.tick = (k % 2) == 1;
  endtask

  // Monitor: every clk the DUT presents a new output word; compare it with the oldest prediction.
  initial begin
    obs_t got;
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      got.hs   = bus.horizontal_sync;
      got.vs   = bus.vertical_sync;
      got.de   = bus.display_en;
      got.rgb  = {bus.red, bus.green, bus.blue};
      got.h    = bus.h_count;
      got.v    = bus.v_count;
      got.tick = bus.pix_tick;
      got.fs   = bus.frame_start;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow @%0t: output seen with no prediction queued", $time);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL obs @%0t got hs=%b vs=%b de=%b rgb=%h h=%0d v=%0d tk=%b fs=%b, exp hs=%b vs=%b de=%b rgb=%h h=%0d v=%0d tk=%b fs=%b",
                   $time, got.hs, got.vs, got.de, got.rgb, got.h, got.v, got.tick, got.fs,
                   exp.hs, exp.vs, exp.de, exp.rgb, exp.h, exp.v, exp.tick, exp.fs);
        end
      end
    end
  end

  // Driver: set the inputs the next edge will sample, predict that edge's outputs, queue them.
  initial begin
    obs_t       e;
    logic       en_r;
    logic       rst_r;
    logic [11:0] ext;
    en_r = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      ext   = 12'($urandom);
      rst_r = 1'b1;
      if (c < 3) begin
        rst_r = 1'b0;
        en_r  = 1'b1;
      end else if (c < 3 + 2 * FRAME_CLKS + 40) begin
        en_r = 1'b1;
      end else if (c < 3 + 3 * FRAME_CLKS + 100) begin
        en_r = 1'b0;
      end else if (c < 3 + 3 * FRAME_CLKS + 140) begin
        en_r = 1'b1;
      end else if (c >= 3000 && c < 3012) begin
        en_r = 1'b0;
      end else if (c >= 3012 && c < 3020) begin
        en_r = 1'b1;
      end else begin
        if ($urandom_range(0, 249) == 0) en_r = ~en_r;
        if ($urandom_range(0, 2999) == 0) rst_r = 1'b0;
      end
      reset      = rst_r;
      bus.enable = en_r;
      bus.R      = ext[11:8];
      bus.G      = ext[7:4];
      bus.B      = ext[3:0];
      model_step(rst_r, en_r, ext, e);
      exp_q.push_back(e);
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d predictions never matched, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_ctrl.md
# vga_frame_ctrl

Frame-level controller for the 640x480@60 Hz VGA output path. Generates the 25 MHz pixel tick from the 50 MHz board clock, sequences the horizontal/vertical counters, and produces sync, display-enable and pixel coordinates. It also arbitrates each visible pixel between the border overlay and the external R/G/B source. Start/stop requests are honoured only at frame boundaries, so the monitor never sees a truncated frame.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- BORDER_W, 11, border thickness in pixels/lines
- BORDER_RGB, 12'h00F, border colour {R,G,B}

Ports:
- clk  in  1  50 MHz board clock; the only clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  run request; level-sensitive
- R, G, B  in  4 each  external pixel colour
- red, green, blue  out  4 each  output colour
- horizontal_sync  out  1  active-low hsync
- vertical_sync  out  1  active-low vsync
- display_en  out  1  high during visible area
- h_count, v_count  out  10 each  current counter values
- pix_tick  out  1  pixel-advance strobe
- frame_start  out  1  one-clk pulse at start of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = 525. Counters are 10-bit unsigned.
- States: IDLE, RUN, DRAIN.
  - IDLE: tick held 0; counters held at (0,0); enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: enable=1 -> RUN, with no counter disturbance. Otherwise, when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0) -> IDLE.
- In RUN and DRAIN, the tick register toggles every clk. pix_tick is the tick register.
- On a clk with pix_tick=1, h_count increments. At H_TOTAL-1 it wraps to 0 and v_count increments. v_count wraps from V_TOTAL-1 to 0 at the same time as h_count wraps.
- Registered output decode (from the current counter values):
  - horizontal_sync = 0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC.
  - vertical_sync: same rule using the V_* parameters.
  - display_en = (h_count < H_VISIBLE) && (v_count < V_VISIBLE) && state != IDLE.
- Pixel arbitration, in priority order:
  - !display_en -> 0.
  - Border pixel -> BORDER_RGB. A border pixel has h_count < BORDER_W, h_count >= H_VISIBLE-BORDER_W, v_count < BORDER_W, or v_count >= V_VISIBLE-BORDER_W.
  - Otherwise -> {R,G,B}, sampled on the same clk.
- frame_start: a single-clk pulse on the first RUN cycle after IDLE, and on the clk after each wrap to (0,0) while not entering IDLE.
- In IDLE: syncs=1, display_en=0, colours=0, frame_start=0.

## Timing
- Reset values (reset=0 on a clk edge): state IDLE, tick 0, h_count 0, v_count 0. Output values: horizontal_sync 1, vertical_sync 1, display_en 0, red/green/blue 0, pix_tick 0, frame_start 0.
- Reset takes effect the same edge it is sampled, including mid-frame. It overrides enable.
- enable rising in IDLE at edge N: state is RUN after edge N; first pix_tick=1 after edge N+1; first counter increment at edge N+2.
- Each pixel lasts exactly 2 clk. A line is 1600 clk; a frame is 840000 clk.
- The decoded outputs (sync, display_en, colour) lag h_count/v_count by exactly 1 clk.
- Deasserting enable mid-frame: the frame completes all V_TOTAL lines, then the block enters IDLE.

## Configuration
- VGA_BORDER_EN defined: border arbitration is compiled in as described above.
- VGA_BORDER_EN undefined: the border logic and the BORDER_* parameters are unused. Every visible pixel outputs {R,G,B}; all other behaviour is identical.

## Test plan
- Reset then idle: reset=0 for 3 clk with enable=1 -> all outputs equal their reset values. After release, frame_start pulses once and counters start advancing at the 2nd clk after release.
- Line timing: R=G=B=4'h5, run one line -> horizontal_sync is low for exactly 192 clk, starting 1 clk after h_count=656. display_en is high for 1280 clk. The h_count=799->0 wrap increments v_count.
- Frame timing: run 2 frames -> vertical_sync is low for v_count 490..491 (3200 clk). frame_start pulses are exactly 840000 clk apart.
- Border (VGA_BORDER_EN defined), R=G=B=4'hA:
  - (h,v)=(10,100) -> 12'h00F.
  - (11,100) -> 12'hAAA.
  - (320,469) -> 12'h00F.
  - (630,240) -> 12'h00F.
  - Without the macro, all four pixels -> 12'hAAA.
- Stop/resume:
  - enable=0 at v_count=200 -> frame runs to (799,524), then enters IDLE with syncs high and counters at 0.
  - enable 0->1 within DRAIN -> no counter discontinuity and no extra frame_start.
- Reset mid-frame at (400,300) -> counters 0 and outputs at reset values on the next clk. No frame_start until enable is sampled high after reset release.
